aqed_resp_checker: RTL and testbench
====================================

# aqed_resp_checker

Read-side responder for the A-QED memory-core harness. Issues read requests to `memory_core`, bounded by write occupancy and a per-iteration `depth` quota. Tracks the response stream in FIFO order, captures the output paired with a write tagged as *original*, and compares it against the output paired with a later write tagged as *duplicate*. Produces the `qed_done`/`qed_check` pair consumed by the top-level `qed_done |-> qed_check` assertion.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of the memory data word
- `CNT_WIDTH`, 16, width of the write/request/response counters and of `depth`

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  reset, synchronous, active-low
- `clk_en`  in  1  global enable; when 0 all state holds and `ren_out` is 0
- `flush`  in  1  synchronous clear; same effect as reset, qualified by `clk_en`
- `depth`  in  CNT_WIDTH  reads allowed per iteration; quasi-static
- `rd_enable`  in  1  permission to issue reads
- `wen_in`  in  1  write accepted by the DUT this cycle
- `orig_mark`  in  1  tags the current write as the original
- `dup_mark`  in  1  tags the current write as the duplicate
- `ren_out`  out  1  read request to the DUT
- `valid_out`  in  1  DUT response valid
- `data_out`  in  DATA_WIDTH  DUT response data
- `qed_done`  out  1  comparison complete (sticky)
- `qed_check`  out  1  original and duplicate outputs matched (sticky)
- `err_underflow`  out  1  response arrived with no outstanding request (sticky)
- `pending`  out  CNT_WIDTH  writes not yet requested, `wr_cnt - rq_cnt` mod 2^CNT_WIDTH

## Operation
- Counters, all modulo 2^CNT_WIDTH:
  - `wr_cnt` increments on `wen_in`.
  - `rq_cnt` increments on `ren_out`.
  - `rsp_cnt` increments on `valid_out`.
  - The n-th response pairs with the n-th write (FIFO order).
- `ren_out = clk_en & rd_enable & (pending != 0) & (rd_iter != depth)`.
- `rd_iter` increments on `ren_out`. When `rd_iter == depth`, it clears to 0 on the next enabled cycle, giving a one-cycle request bubble per iteration.
- If `depth == 0`, `ren_out` stays 0.
- FSM states: IDLE, ARMED, CAPT, DONE.
  - IDLE → ARMED on `wen_in & orig_mark`; latch `orig_idx <= wr_cnt`.
  - ARMED → CAPT on `valid_out & rsp_cnt == orig_idx`; latch `orig_data <= data_out`.
  - CAPT → DONE on `valid_out & dup_vld & rsp_cnt == dup_idx`. Set `qed_done <= 1` and `qed_check <= (data_out == orig_data)`.
  - DONE holds until reset or flush.
- Duplicate tag: in ARMED or CAPT with `dup_vld == 0`, `wen_in & dup_mark` latches `dup_idx <= wr_cnt` and sets `dup_vld`.
  - Further marks are ignored.
  - Marks without `wen_in` are ignored.
  - `orig_mark` outside IDLE is ignored.
- If `orig_mark` and `dup_mark` arrive on the same write in IDLE, only the original is taken.
- `err_underflow` is set on `valid_out & (rsp_cnt == rq_cnt)`. In that case `rsp_cnt` does not increment.

## Timing
- Reset/flush values:
  - `ren_out`=0, `qed_done`=0, `qed_check`=0, `err_underflow`=0, `pending`=0.
  - All counters 0, state IDLE, `dup_vld`=0.
- `ren_out` is combinational from registered state plus `clk_en`/`rd_enable`. A write at cycle t enables a request at t+1.
- Tag-to-response latency is set by the DUT. The capture and the compare are each registered one cycle after the matching `valid_out`.
- A write and a read in the same cycle: both counters update and `pending` is unchanged.
- Reset or flush in the middle of a comparison discards the tags and returns to IDLE. Flush is ignored when `clk_en`=0; reset is not.
- Response with `clk_en`=0: ignored (the DUT produces none when gated).

## Structure
- Package `aqed_pkg`: FSM state enum `aqed_resp_state_t`, default widths, counter typedef.
- Sub-module `aqed_iter_ctr`: the `rd_iter` counter with depth compare and clear-after-hit. It is reused by the write-side stimulus block.
- Remaining logic is flat.

## Test plan
- Write data 0x11,0x22,0x33 with orig on #0, then write 0x11 with dup on #3, `depth`=4; DUT returns in order → `qed_done`=1, `qed_check`=1 one cycle after the 4th `valid_out`.
- Same as above, but the DUT returns 0x12 for #3 → `qed_done`=1, `qed_check`=0.
- `depth`=3, 6 writes, `rd_enable`=1 → `ren_out` high for 3 cycles, a 1-cycle gap, then 3 more; `pending` ends at 0.
- `valid_out` pulse with no request issued → `err_underflow`=1 and `rsp_cnt` stays 0.
- Orig tagged, then `flush` before the dup response → outputs 0, state IDLE; a fresh orig/dup pair then completes normally.
- `orig_mark` & `dup_mark` on the same write, then dup on a later write → the comparison uses the later write; `depth`=0 → `ren_out` never asserts.

Source files
------------

// File: rtl/aqed_pkg.sv
// Shared types and default widths for the A-QED read-side responder.
package aqed_pkg;

  localparam int unsigned AQED_DATA_WIDTH = 16;
  localparam int unsigned AQED_CNT_WIDTH  = 16;

  typedef logic [AQED_CNT_WIDTH-1:0] aqed_cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } aqed_resp_state_t;

endpackage

// File: rtl/aqed_iter_ctr.sv
// Per-iteration request counter: counts issued operations up to depth, then
// clears on the next enabled cycle, leaving a one-cycle bubble per iteration.
module aqed_iter_ctr #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 flush,
  input  logic [CNT_WIDTH-1:0] depth,
  input  logic                 inc,
  output logic                 hit
);

  logic [CNT_WIDTH-1:0] iter;

  assign hit = (iter == depth);

  // Advance on each issued operation; wrap to zero once the quota is reached.
  always_ff @(posedge clk) begin
    if (!reset) begin
      iter <= '0;
    end else if (clk_en) begin
      if (flush || hit) begin
        iter <= '0;
      end else if (inc) begin
        iter <= iter + 1'b1;
      end
    end
  end

endmodule

// File: rtl/aqed_resp_checker.sv
// A-QED read-side responder: issues reads, tracks responses in FIFO order and
// compares the output paired with the original write against the duplicate's.
module aqed_resp_checker
  import aqed_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AQED_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = AQED_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [CNT_WIDTH-1:0]  depth,
  input  logic                  rd_enable,
  input  logic                  wen_in,
  input  logic                  orig_mark,
  input  logic                  dup_mark,
  output logic                  ren_out,
  input  logic                  valid_out,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  qed_done,
  output logic                  qed_check,
  output logic                  err_underflow,
  output logic [CNT_WIDTH-1:0]  pending
);

  aqed_resp_state_t state;

  logic [CNT_WIDTH-1:0]  wr_cnt;
  logic [CNT_WIDTH-1:0]  rq_cnt;
  logic [CNT_WIDTH-1:0]  rsp_cnt;
  logic [CNT_WIDTH-1:0]  orig_idx;
  logic [CNT_WIDTH-1:0]  dup_idx;
  logic                  dup_vld;
  logic [DATA_WIDTH-1:0] orig_data;
  logic                  iter_hit;
  logic                  clr;
  logic                  rsp_in;
  logic                  rsp_under;

  assign clr       = clk_en & flush;
  assign rsp_in    = clk_en & valid_out;
  assign rsp_under = rsp_in & (rsp_cnt == rq_cnt);
  assign pending   = wr_cnt - rq_cnt;
  assign ren_out   = clk_en & rd_enable & (pending != '0) & ~iter_hit;

  aqed_iter_ctr #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_rd_iter (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .flush  (flush),
    .depth  (depth),
    .inc    (ren_out),
    .hit    (iter_hit)
  );

  // Write, request and response counters plus the sticky underflow flag.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      wr_cnt        <= '0;
      rq_cnt        <= '0;
      rsp_cnt       <= '0;
      err_underflow <= 1'b0;
    end else if (clk_en) begin
      if (wen_in)    wr_cnt  <= wr_cnt + 1'b1;
      if (ren_out)   rq_cnt  <= rq_cnt + 1'b1;
      if (rsp_under) err_underflow <= 1'b1;
      else if (rsp_in) rsp_cnt <= rsp_cnt + 1'b1;
    end
  end

  // Tag capture and compare FSM with registered done/check outputs.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      state     <= IDLE;
      orig_idx  <= '0;
      dup_idx   <= '0;
      dup_vld   <= 1'b0;
      orig_data <= '0;
      qed_done  <= 1'b0;
      qed_check <= 1'b0;
    end else if (clk_en) begin
      // Duplicate tag is only accepted after the original, and only once.
      if ((state == ARMED || state == CAPT) && !dup_vld && wen_in && dup_mark) begin
        dup_idx <= wr_cnt;
        dup_vld <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (wen_in && orig_mark) begin
            orig_idx <= wr_cnt;
            state    <= ARMED;
          end
        end
        ARMED: begin
          if (valid_out && rsp_cnt == orig_idx) begin
            orig_data <= data_out;
            state     <= CAPT;
          end
        end
        CAPT: begin
          if (valid_out && dup_vld && rsp_cnt == dup_idx) begin
            qed_done  <= 1'b1;
            qed_check <= (data_out == orig_data);
            state     <= DONE;
          end
        end
        default: begin
          state <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aqed_resp_checker.sv
// Directed bench for aqed_resp_checker with an in-order memory responder.
module tb_aqed_resp_checker;
  import aqed_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        flush;
  logic [15:0] depth;
  logic        rd_enable;
  logic        wen_in;
  logic        orig_mark;
  logic        dup_mark;
  logic        ren_out;
  logic        valid_out;
  logic [15:0] data_out;
  logic        qed_done;
  logic        qed_check;
  logic        err_underflow;
  logic [15:0] pending;

  int          checks   = 0;
  int          failures = 0;

  // Bench-side memory model: data written, served back in order.
  logic [15:0] wmem [0:63];
  int          wr_n;
  int          rd_n;
  int          corrupt_idx;
  logic [15:0] corrupt_val;
  logic        rsp_due;
  logic [15:0] rsp_data;
  int          ren_seen;
  logic [15:0] ren_hist;

  aqed_resp_checker #(
    .DATA_WIDTH (16),
    .CNT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .flush         (flush),
    .depth         (depth),
    .rd_enable     (rd_enable),
    .wen_in        (wen_in),
    .orig_mark     (orig_mark),
    .dup_mark      (dup_mark),
    .ren_out       (ren_out),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .qed_done      (qed_done),
    .qed_check     (qed_check),
    .err_underflow (err_underflow),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    wr_n        = 0;
    rd_n        = 0;
    rsp_due     = 1'b0;
    rsp_data    = '0;
    corrupt_idx = -1;
    corrupt_val = '0;
    ren_seen    = 0;
    ren_hist    = '0;
  endtask

  // One clock: drive inputs at negedge, respond to requests one cycle later.
  task automatic tick(input logic w, input logic o, input logic d, input logic [15:0] wd);
    @(negedge clk);
    wen_in    = w;
    orig_mark = o;
    dup_mark  = d;
    if (w) begin
      wmem[wr_n] = wd;
      wr_n++;
    end
    valid_out = rsp_due;
    data_out  = rsp_due ? rsp_data : 16'h0;
    #1;
    rsp_due  = ren_out;
    ren_hist = {ren_hist[14:0], ren_out};
    if (ren_out) begin
      ren_seen++;
      rsp_data = (rd_n == corrupt_idx) ? corrupt_val : wmem[rd_n];
      rd_n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    clk_en    = 1'b1;
    flush     = 1'b0;
    rd_enable = 1'b0;
    rsp_due   = 1'b0;
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    clear_model();
  endtask

  initial begin
    reset = 1'b0; clk_en = 1'b1; flush = 1'b0; depth = 16'd4; rd_enable = 1'b0;
    wen_in = 1'b0; orig_mark = 1'b0; dup_mark = 1'b0; valid_out = 1'b0; data_out = '0;
    clear_model();
    do_reset();

    // Reset state
    rd_enable = 1'b1;
    #1;
    check("rst_ren", ren_out, 0);
    check("rst_done", qed_done, 0);
    check("rst_check", qed_check, 0);
    check("rst_under", err_underflow, 0);
    check("rst_pending", pending, 0);

    // Matching original/duplicate, depth 4
    tick(1'b1, 1'b1, 1'b0, 16'h11);
    tick(1'b1, 1'b0, 1'b0, 16'h22);
    tick(1'b1, 1'b0, 1'b0, 16'h33);
    tick(1'b1, 1'b0, 1'b1, 16'h11);
    tick(1'b0, 1'b0, 1'b0, 16'h0);
    check("match_done_early", qed_done, 0);
    tick(1'b0, 1'b0, 1'b0, 16'h0);
    check("match_done", qed_done, 1);
    check("match_check", qed_check, 1);
    check("match_pending", pending, 0);
    idle(3);
    check("match_sticky", {qed_done, qed_check}, 2'b11);

    // Mismatching duplicate response
    do_reset();
    depth = 16'd4; rd_enable = 1'b1;
    corrupt_idx = 3; corrupt_val = 16'h12;
    tick(1'b1, 1'b1, 1'b0, 16'h11);
    tick(1'b1, 1'b0, 1'b0, 16'h22);
    tick(1'b1, 1'b0, 1'b0, 16'h33);
    tick(1'b1, 1'b0, 1'b1, 16'h11);
    idle(2);
    check("mism_done", qed_done, 1);
    check("mism_check", qed_check, 0);

    // depth 3, six back-to-back writes: 3 requests, bubble, 3 requests
    do_reset();
    depth = 16'd3; rd_enable = 1'b1;
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 16'(i));
    idle(3);
    check("iter_pattern", ren_hist[8:0], 9'b011101110);
    check("iter_count", ren_seen, 6);
    check("iter_pending", pending, 0);
    check("iter_under", err_underflow, 0);

    // Response with nothing outstanding
    do_reset();
    depth = 16'd4; rd_enable = 1'b1;
    rsp_due = 1'b1; rsp_data = 16'hAA;
    idle(1);
    check("under_flag", err_underflow, 1);
    check("under_rsp_cnt", dut.rsp_cnt, 0);

    // Flush mid-comparison, gated flush ignored, then a fresh pair
    do_reset();
    depth = 16'd4; rd_enable = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 16'h40);
    tick(1'b1, 1'b0, 1'b1, 16'h41);
    check("flush_pre_pending", pending, 2);
    clk_en = 1'b0; flush = 1'b1; rd_enable = 1'b1;
    idle(1);
    check("gated_flush_pending", pending, 2);
    check("gated_flush_state", dut.state, ARMED);
    clk_en = 1'b1;
    rd_enable = 1'b0;
    idle(1);
    flush = 1'b0;
    clear_model();
    check("flush_pending", pending, 0);
    check("flush_state", dut.state, IDLE);
    check("flush_outs", {qed_done, qed_check, err_underflow}, 3'b000);
    rd_enable = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 16'h55);
    tick(1'b1, 1'b0, 1'b1, 16'h55);
    idle(3);
    check("flush_pair_done", {qed_done, qed_check}, 2'b11);

    // orig+dup on one write: only orig taken; later dup used, further dup ignored
    do_reset();
    depth = 16'd4; rd_enable = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 16'h70);
    tick(1'b1, 1'b0, 1'b0, 16'h71);
    tick(1'b1, 1'b0, 1'b1, 16'h70);
    tick(1'b1, 1'b0, 1'b1, 16'h00);
    idle(3);
    check("dual_mark_done", {qed_done, qed_check}, 2'b11);
    check("dual_mark_idx", dut.dup_idx, 2);

    // depth 0 never requests
    do_reset();
    depth = 16'd0; rd_enable = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 16'(i));
    idle(5);
    check("depth0_ren", ren_seen, 0);
    check("depth0_pending", pending, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
